// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB command master:
//   - apb_state_t : bus-phase state of the master FSM (IDLE / SETUP / ACCESS)
//   - apb_cmd_t   : queued command {write, addr, wdata} at the default bus widths
//   - register-map address constants of the target peripheral
//   - centroid_addr() : address of centroid register 1..8 from a 0-based index
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 91;

  // Default-width command record. The master lays out its queue entries with
  // the same field order at whatever widths it is parameterised with.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  // Register map of the completer
  localparam logic [APB_ADDR_W-1:0] ADDR_INTERNAL_STATUS = 8'd0;
  localparam logic [APB_ADDR_W-1:0] ADDR_GO              = 8'd1;
  localparam logic [APB_ADDR_W-1:0] ADDR_CENTROID_BASE   = 8'd2;  // centroid 1 .. centroid 8 = 2 .. 9
  localparam int                    NUM_CENTROIDS        = 8;
  localparam logic [APB_ADDR_W-1:0] ADDR_RAM_ADDR        = 8'd10;
  localparam logic [APB_ADDR_W-1:0] ADDR_RAM_DATA        = 8'd11;
  localparam logic [APB_ADDR_W-1:0] ADDR_FIRST_RAM_ADDR  = 8'd12;
  localparam logic [APB_ADDR_W-1:0] ADDR_LAST_RAM_ADDR   = 8'd13;

  // idx 0 selects centroid 1, idx 7 selects centroid 8
  function automatic logic [APB_ADDR_W-1:0] centroid_addr(input logic [2:0] idx);
    return ADDR_CENTROID_BASE + {5'd0, idx};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous show-ahead FIFO. The head entry is read directly out of the
// storage registers, so o_rdata is valid whenever o_empty is low and advances
// on the edge where i_pop is accepted.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_wdata: write request and data (ignored while full)
//   i_pop         : remove head entry (ignored while empty)
//   o_rdata       : head entry
//   o_full/o_empty: occupancy flags
//   o_count       : number of stored entries
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; no reset needed since an empty FIFO never exposes stale data
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
// Queues read/write commands in a FIFO and replays them, in order, as APB
// transfers. Each transfer produces a one-cycle rsp_valid pulse; a transfer
// whose completer never asserts pready within TIMEOUT ACCESS cycles is
// aborted and reported with rsp_error.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake (cmd_ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata  : command payload
//   rsp_valid/rsp_rdata/rsp_error : completion pulse, read data, timeout flag
//   busy                          : work queued or a transfer in progress
//   paddr/pwrite/psel/penable/pwdata : APB request (all registered)
//   prdata/pready                 : APB completer response
// -----------------------------------------------------------------------------
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 91,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  typedef struct packed {
    logic                 write;
    logic [addrWidth-1:0] addr;
    logic [dataWidth-1:0] wdata;
  } cmd_t;

  localparam int               CMD_W    = $bits(cmd_t);
  localparam int               OCC_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Wait counter value during the last ACCESS cycle allowed before an abort
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Registered state and outputs
  apb_state_t           r_state;
  logic                 r_psel;
  logic                 r_penable;
  logic [addrWidth-1:0] r_paddr;
  logic                 r_pwrite;
  logic [dataWidth-1:0] r_pwdata;
  logic                 r_rsp_valid;
  logic                 r_rsp_error;
  logic [dataWidth-1:0] r_rsp_rdata;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;

  // Next-state values
  apb_state_t           w_state_nxt;
  logic                 w_psel_nxt;
  logic                 w_penable_nxt;
  logic [addrWidth-1:0] w_paddr_nxt;
  logic                 w_pwrite_nxt;
  logic [dataWidth-1:0] w_pwdata_nxt;
  logic                 w_rsp_valid_nxt;
  logic                 w_rsp_error_nxt;
  logic [dataWidth-1:0] w_rsp_rdata_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_busy_nxt;

  // FIFO interface
  cmd_t                 w_fifo_wdata;
  cmd_t                 w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [OCC_W-1:0]     w_count;
  logic [OCC_W-1:0]     w_occ_nxt;

  assign w_fifo_wdata = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign w_push       = cmd_valid && !w_full;
  assign cmd_ready    = !w_full;
  // Occupancy after this edge, used to register busy one cycle ahead
  assign w_occ_nxt    = w_count + OCC_W'(w_push) - OCC_W'(w_pop);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // FSM state, APB request and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_error <= w_rsp_error_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic of the transfer sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_paddr_nxt     = r_paddr;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_error_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_cnt_nxt       = r_cnt;
    w_pop           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_paddr_nxt   = w_head.addr;
          w_pwrite_nxt  = w_head.write;
          w_pwdata_nxt  = w_head.wdata;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = ST_SETUP;
        end else begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
        end
      end

      ST_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready is checked before the timeout so a late pready still completes
        if (pready) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
          if (!w_empty) begin
            // Back-to-back: next command goes straight to SETUP, psel stays high
            w_pop         = 1'b1;
            w_paddr_nxt   = w_head.addr;
            w_pwrite_nxt  = w_head.write;
            w_pwdata_nxt  = w_head.wdata;
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b0;
            w_state_nxt   = ST_SETUP;
          end else begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            w_state_nxt   = ST_IDLE;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_error_nxt = 1'b1;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE) || (w_occ_nxt != '0);
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
// Randomised bench for apb_cmd_master with a transaction-level reference
// model: a queue of accepted commands, the command in flight and its age in
// cycles (0 = setup phase, n = n-th access cycle). Directed sections cover
// single write, read with wait states, full FIFO, timeout, reset mid-transfer
// and back-to-back register writes.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 91;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          busy;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .addrWidth (AW),
    .dataWidth (DW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .busy     (busy),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .psel     (psel),
    .penable  (penable),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_s;

  // Reference model state
  cmd_s          q[$];
  cmd_s          cur;
  bit            m_active;
  int            m_age;
  bit            m_pushed;
  bit            e_rv;
  bit            e_re;
  logic [DW-1:0] e_rd;

  // Completer behaviour and monitors
  int            wq[$];
  int            tgt;
  bit            fix_rd;
  logic [DW-1:0] fix_rd_val;
  logic [AW-1:0] setup_q[$];
  int            cyc;
  int            n_rsp;
  int            n_full;
  int            n_checks;
  int            n_errors;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model across one rising edge using the inputs present at it
  task automatic model_update();
    bit   done;
    bit   abort;
    bit   push;
    cmd_s c;
    cyc++;
    m_pushed = 1'b0;
    e_rv = 1'b0;
    e_re = 1'b0;
    e_rd = '0;
    if (rst) begin
      q.delete();
      m_active = 1'b0;
      m_age = 0;
      return;
    end
    push   = cmd_valid && (q.size() < DEPTH);
    c.wr   = cmd_write;
    c.addr = cmd_addr;
    c.data = cmd_wdata;
    done   = 1'b0;
    abort  = 1'b0;
    if (m_active) begin
      if (m_age == 0) begin
        m_age = 1;
      end else if (pready) begin
        done = 1'b1;
        e_rv = 1'b1;
        e_rd = cur.wr ? '0 : prdata;
      end else if (m_age == TMO) begin
        done  = 1'b1;
        abort = 1'b1;
        e_rv  = 1'b1;
        e_re  = 1'b1;
      end else begin
        m_age++;
      end
    end
    if ((!m_active || (done && !abort)) && q.size() > 0) begin
      cur = q.pop_front();
      m_active = 1'b1;
      m_age = 0;
    end else if (done) begin
      m_active = 1'b0;
    end
    if (push) begin
      q.push_back(c);
      m_pushed = 1'b1;
    end
  endtask

  task automatic compare();
    check_eq("psel", psel, m_active);
    check_eq("penable", penable, m_active && (m_age >= 1));
    if (m_active) begin
      check_eq("paddr", paddr, cur.addr);
      check_eq("pwrite", pwrite, cur.wr);
      check_eq("pwdata", pwdata, cur.data);
    end
    check_eq("rsp_valid", rsp_valid, e_rv);
    if (e_rv) begin
      check_eq("rsp_error", rsp_error, e_re);
      check_eq("rsp_rdata", rsp_rdata, e_rd);
    end
    check_eq("cmd_ready", cmd_ready, q.size() < DEPTH);
    check_eq("busy", busy, m_active || (q.size() > 0));
    if (rsp_valid) n_rsp++;
    if (!cmd_ready) n_full++;
    if (psel && !penable) setup_q.push_back(paddr);
  endtask

  // Completer: pready after a chosen number of wait states, random outside ACCESS
  task automatic drive_completer();
    if (m_active && m_age >= 1) begin
      if (m_age == 1) begin
        if (wq.size() > 0) tgt = wq.pop_front();
        else tgt = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 4));
      end
      pready = ((m_age - 1) == tgt);
    end else begin
      pready = 1'($urandom_range(0, 1));
    end
    prdata = fix_rd ? fix_rd_val : DW'({$urandom, $urandom, $urandom});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    drive_completer();
  endtask

  task automatic offer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc_cyc);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    do begin
      cycle();
      guard++;
    end while (!m_pushed && guard < 200);
    check_eq("accept_bound", m_pushed, 1'b1);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'({$urandom, $urandom, $urandom});
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    cmd_valid = 1'b0;
    while ((m_active || q.size() > 0) && g < 2000) begin
      cycle();
      g++;
    end
    check_eq(tag, m_active || (q.size() > 0), 1'b0);
  endtask

  initial begin
    int a, g, np, ne, base, gaps, full0;
    bit e1, e2;
    n_checks = 0; n_errors = 0; cyc = 0; n_rsp = 0; n_full = 0;
    m_active = 1'b0; m_age = 0; tgt = 0; fix_rd = 1'b0; fix_rd_val = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; prdata = '0;

    // Reset state
    repeat (2) cycle();
    check_eq("rst_paddr", paddr, '0);
    check_eq("rst_pwdata", pwdata, '0);
    check_eq("rst_pwrite", pwrite, 1'b0);
    check_eq("rst_rsp_error", rsp_error, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, '0);
    rst = 1'b0;
    cycle();

    // Single write with zero wait states
    wq.push_back(0);
    offer(1'b1, ADDR_GO, DW'(1), a);
    np = 0; ne = 0; g = 0;
    while (!rsp_valid && g < 30) begin
      np += int'(psel); ne += int'(penable);
      cycle(); g++;
    end
    check_eq("w_done", rsp_valid, 1'b1);
    check_eq("w_latency", cyc - a, 3);
    check_eq("w_psel_cycles", np, 2);
    check_eq("w_penable_cycles", ne, 1);
    check_eq("w_rdata", rsp_rdata, '0);
    check_eq("w_error", rsp_error, 1'b0);
    cycle();

    // Read with three wait states
    wq.push_back(3);
    fix_rd = 1'b1; fix_rd_val = 91'h1234;
    offer(1'b0, centroid_addr(3'd0), DW'($urandom), a);
    ne = 0; g = 0;
    while (!rsp_valid && g < 30) begin
      ne += int'(penable);
      cycle(); g++;
    end
    fix_rd = 1'b0;
    check_eq("r_done", rsp_valid, 1'b1);
    check_eq("r_access_cycles", ne, 4);
    check_eq("r_latency", cyc - a, 6);
    check_eq("r_rdata", rsp_rdata, 91'h1234);
    drain("r_idle");

    // Back-to-back commands with a stalled completer fill the FIFO
    repeat (6) wq.push_back(6);
    base = n_rsp; full0 = n_full;
    for (int i = 0; i < 6; i++) offer(1'($urandom), AW'(8'h20 + 8'(i)), DW'({$urandom, $urandom, $urandom}), a);
    check_eq("ff_full_seen", n_full > full0, 1'b1);
    gaps = 0; g = 0;
    while (n_rsp < base + 6 && g < 300) begin
      gaps += int'(!psel);
      cycle(); g++;
    end
    check_eq("ff_rsp_count", n_rsp - base, 6);
    check_eq("ff_idle_gaps", gaps, 0);
    drain("ff_idle");

    // Timeout on the first command, normal completion of the second
    wq.push_back(1000);
    wq.push_back(0);
    base = n_rsp;
    offer(1'b1, ADDR_FIRST_RAM_ADDR, DW'(8'h33), a);
    offer(1'b0, ADDR_LAST_RAM_ADDR, DW'(0), a);
    ne = 0; g = 0; e1 = 1'b0; e2 = 1'b1;
    while (n_rsp < base + 2 && g < 100) begin
      if (n_rsp == base) ne += int'(penable);
      cycle(); g++;
      if (rsp_valid && n_rsp == base + 1) e1 = rsp_error;
      if (rsp_valid && n_rsp == base + 2) e2 = rsp_error;
    end
    check_eq("to_rsp_count", n_rsp - base, 2);
    check_eq("to_access_cycles", ne, TMO);
    check_eq("to_first_error", e1, 1'b1);
    check_eq("to_second_error", e2, 1'b0);
    drain("to_idle");

    // Two register writes: address order and stable data per transfer
    wq.push_back(0);
    wq.push_back(0);
    setup_q.delete();
    base = n_rsp;
    offer(1'b1, ADDR_RAM_ADDR, DW'(8'h40), a);
    offer(1'b1, ADDR_RAM_DATA, DW'(8'h55), a);
    g = 0;
    while (n_rsp < base + 2 && g < 50) begin
      cycle(); g++;
    end
    check_eq("rw_setups", setup_q.size(), 2);
    if (setup_q.size() >= 2) begin
      check_eq("rw_addr0", setup_q[0], 8'h0A);
      check_eq("rw_addr1", setup_q[1], 8'h0B);
    end
    drain("rw_idle");

    // Reset while in ACCESS with two commands queued
    repeat (3) wq.push_back(100);
    for (int i = 0; i < 3; i++) offer(1'b0, AW'(8'h40 + 8'(i)), '0, a);
    g = 0;
    while (!(m_active && m_age >= 1 && q.size() == 2) && g < 20) begin
      cycle(); g++;
    end
    check_eq("mr_reached", penable, 1'b1);
    base = n_rsp;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wq.delete();
    check_eq("mr_psel", psel, 1'b0);
    check_eq("mr_ready", cmd_ready, 1'b1);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_no_rsp", n_rsp - base, 0);
    repeat (3) cycle();
    check_eq("mr_quiet", n_rsp - base, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom_range(0, 13));
      cmd_wdata = DW'({$urandom, $urandom, $urandom});
      cycle();
    end
    drain("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
